// File: rtl/reverb_template_m2s_fifo.sv
// ---------------------------------------------------------------------------
// reverb_template_m2s_fifo
//
// Transmit-side FIFO for the reverb template. Nios software writes 32-bit
// audio/coefficient words over an Avalon-MM write slave. The block buffers
// them and presents them in order on a show-ahead Avalon-ST source that
// feeds the reverb datapath.
//
// Register map (avalonmm_write_slave_address):
//   0 : data port.   A write pushes writedata; a read returns 0.
//   1 : control/status. A write with writedata[0]=1 flushes the FIFO.
//                    A read returns the fill level, zero-extended.
//
// Ports
//   wrclock                          single clock for all logic
//   reset                            synchronous, active-high
//   avalonmm_write_slave_address     0 = data, 1 = control/status
//   avalonmm_write_slave_write       MM write strobe
//   avalonmm_write_slave_writedata   MM write data
//   avalonmm_write_slave_read        MM read strobe
//   avalonmm_write_slave_readdata    registered read data, readLatency 1
//   avalonmm_write_slave_waitrequest stalls the master (reset, or push into full FIFO)
//   avalonst_source_data             head-of-FIFO word
//   avalonst_source_valid            head word is valid (FIFO not empty)
//   avalonst_source_ready            sink accepts, readyLatency 0
//   level                            words currently stored, 0..DEPTH
// ---------------------------------------------------------------------------
module reverb_template_m2s_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  wrclock,
    input  logic                  reset,
    input  logic                  avalonmm_write_slave_address,
    input  logic                  avalonmm_write_slave_write,
    input  logic [DATA_WIDTH-1:0] avalonmm_write_slave_writedata,
    input  logic                  avalonmm_write_slave_read,
    output logic [DATA_WIDTH-1:0] avalonmm_write_slave_readdata,
    output logic                  avalonmm_write_slave_waitrequest,
    output logic [DATA_WIDTH-1:0] avalonst_source_data,
    output logic                  avalonst_source_valid,
    input  logic                  avalonst_source_ready,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage carries no reset: contents are don't-care until written.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic [DATA_WIDTH-1:0] readdata_p1;

    logic full;
    logic empty;
    logic data_sel;
    logic ctrl_sel;
    logic push;
    logic pop;
    logic flush;

    assign full     = (level_q == FULL_LEVEL);
    assign empty    = (level_q == '0);
    assign data_sel = (avalonmm_write_slave_address == 1'b0);
    assign ctrl_sel = (avalonmm_write_slave_address == 1'b1);

    // full is the pre-edge value, so a pop in the same cycle never frees
    // room for a push; the stalled write lands one cycle after the pop.
    assign push  = avalonmm_write_slave_write & data_sel & ~full & ~reset;
    assign pop   = avalonst_source_valid & avalonst_source_ready;
    assign flush = avalonmm_write_slave_write & ctrl_sel &
                   avalonmm_write_slave_writedata[0] & ~reset;

    assign avalonmm_write_slave_waitrequest =
        reset | (avalonmm_write_slave_write & data_sel & full);

    assign avalonst_source_valid         = ~empty;
    assign avalonst_source_data          = mem[rd_ptr];
    assign avalonmm_write_slave_readdata = readdata_p1;
    assign level                         = level_q;

    // Write port of the storage array.
    always_ff @(posedge wrclock) begin
        if (push) begin
            mem[wr_ptr] <= avalonmm_write_slave_writedata;
        end
    end

    // Pointers and fill level. Flush beats any pop in the same cycle; a
    // flush and a push cannot coincide since they use different addresses.
    always_ff @(posedge wrclock) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Status read, readLatency 1. Returns the level seen in the read cycle;
    // the bus is driven to zero whenever no status read is in progress.
    always_ff @(posedge wrclock) begin
        if (reset) begin
            readdata_p1 <= '0;
        end else if (avalonmm_write_slave_read && ctrl_sel) begin
            readdata_p1 <= {{(DATA_WIDTH - ADDR_WIDTH - 1){1'b0}}, level_q};
        end else begin
            readdata_p1 <= '0;
        end
    end

endmodule

// File: tb/tb_reverb_template_m2s_fifo.sv
module tb_reverb_template_m2s_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          address;
    logic          write;
    logic [DW-1:0] writedata;
    logic          read;
    logic [DW-1:0] readdata;
    logic          waitrequest;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic [AW:0]   level;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model: a queue holding the stored words, head at index 0.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd = '0;
    logic [DW-1:0] words[DEPTH];

    reverb_template_m2s_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .wrclock                          (clk),
        .reset                            (reset),
        .avalonmm_write_slave_address     (address),
        .avalonmm_write_slave_write       (write),
        .avalonmm_write_slave_writedata   (writedata),
        .avalonmm_write_slave_read        (read),
        .avalonmm_write_slave_readdata    (readdata),
        .avalonmm_write_slave_waitrequest (waitrequest),
        .avalonst_source_data             (src_data),
        .avalonst_source_valid            (src_valid),
        .avalonst_source_ready            (src_ready),
        .level                            (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs only change 1 time unit after posedge, so at negedge they are the
    // values the DUT will sample on the coming edge: compare first, then advance.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_full;
            bit do_push;
            bit do_pop;
            exp_full = (q.size() == DEPTH);
            chk("model_level", 32'(level), 32'(q.size()));
            chk("model_valid", 32'(src_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("model_data", src_data, q[0]);
            chk("model_waitreq", 32'(waitrequest),
                32'(reset | (write & (address == 1'b0) & exp_full)));
            chk("model_readdata", readdata, exp_rd);
            if (reset) begin
                q.delete();
                exp_rd = '0;
            end else begin
                exp_rd  = (read && address) ? DW'(q.size()) : '0;
                do_push = write && (address == 1'b0) && !exp_full;
                do_pop  = (q.size() != 0) && src_ready;
                if (write && address && writedata[0]) begin
                    q.delete();
                end else begin
                    if (do_pop)  void'(q.pop_front());
                    if (do_push) q.push_back(writedata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mm_write(input logic a, input logic [DW-1:0] d);
        bit done;
        done      = 0;
        address   = a;
        writedata = d;
        write     = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) done = 1;
            step();
        end
        write = 1'b0;
        if (!done) chk("write_timeout", 32'd1, 32'd0);
    endtask

    task automatic mm_read(input logic a);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        chk("read_no_waitreq", 32'(waitrequest), 32'd0);
        step();
        read = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) mm_write(1'b0, $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = 1'b0; write = 1'b0; writedata = '0;
        read = 1'b0; src_ready = 1'b0;
        step(); step();
        chk("reset_waitreq", 32'(waitrequest), 32'd1);
        chk("reset_valid", 32'(src_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        reset  = 1'b0;
        chk_en = 1;

        // 1: three words through with ready=1
        src_ready = 1'b1;
        mm_write(1'b0, 32'h11);
        chk("t1_first_valid", 32'(src_valid), 32'd1);
        chk("t1_first_data", src_data, 32'h11);
        mm_write(1'b0, 32'h22);
        chk("t1_second_data", src_data, 32'h22);
        mm_write(1'b0, 32'h33);
        chk("t1_third_data", src_data, 32'h33);
        step(); step();
        chk("t1_level_zero", 32'(level), 32'd0);

        // 2: fill to full, stall, release with one ready pulse
        src_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = $urandom;
            mm_write(1'b0, words[i]);
        end
        chk("t2_level_full", 32'(level), 32'd32);
        address = 1'b0; writedata = 32'hCAFE_0033; write = 1'b1;
        @(negedge clk);
        chk("t2_stall", 32'(waitrequest), 32'd1);
        step();
        src_ready = 1'b1;
        @(negedge clk);
        chk("t2_still_stalled", 32'(waitrequest), 32'd1);
        step();
        src_ready = 1'b0;
        chk("t2_level_after_pop", 32'(level), 32'd31);
        @(negedge clk);
        chk("t2_released", 32'(waitrequest), 32'd0);
        step();
        write = 1'b0;
        chk("t2_level_refull", 32'(level), 32'd32);
        chk("t2_head", src_data, words[1]);

        // 3: level 5, push and pop every cycle across pointer wrap
        mm_write(1'b1, 32'h1);
        fill(5);
        src_ready = 1'b1; address = 1'b0; write = 1'b1;
        for (int i = 0; i < 40; i++) begin
            writedata = $urandom;
            step();
        end
        write = 1'b0; src_ready = 1'b0;
        chk("t3_level_hold", 32'(level), 32'd5);

        // 4: level 10, flush while ready=1
        mm_write(1'b1, 32'h0);
        chk("t4_noflush_level", 32'(level), 32'd5);
        fill(5);
        chk("t4_level10", 32'(level), 32'd10);
        src_ready = 1'b1;
        mm_write(1'b1, 32'h1);
        chk("t4_valid_cleared", 32'(src_valid), 32'd0);
        chk("t4_level_cleared", 32'(level), 32'd0);
        mm_read(1'b1);
        chk("t4_status_zero", readdata, 32'd0);
        src_ready = 1'b0;

        // 5: level 3, reset during an active write
        fill(3);
        address = 1'b0; writedata = 32'hDEAD_BEEF; write = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("t5_waitreq_rst", 32'(waitrequest), 32'd1);
        step(); step();
        reset = 1'b0; write = 1'b0; src_ready = 1'b1;
        chk("t5_valid", 32'(src_valid), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        step(); step();
        chk("t5_no_stale", 32'(src_valid), 32'd0);
        src_ready = 1'b0;

        // 6: status read at level 17
        fill(17);
        mm_read(1'b1);
        chk("t6_status17", readdata, 32'h0000_0011);
        mm_read(1'b0);
        chk("t6_addr0_read", readdata, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            write     = $urandom_range(0, 3) != 0;
            address   = ($urandom_range(0, 15) == 0);
            writedata = $urandom;
            read      = $urandom_range(0, 3) == 0;
            src_ready = (i % 600 < 300) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; write = 1'b0; read = 1'b0; src_ready = 1'b1;
        repeat (40) step();
        chk("final_drained", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
